iob_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one IOb slave port among N_MASTERS IOb masters
//  (e.g. CPU, DMA, AXI-Lite bridge). Only one transaction is outstanding at a time.
//  The grant is held from request through completion: ready for writes, rvalid for reads.

---
 rtl/iob_rr_arbiter_pkg.sv | 15 +
 rtl/iob_rr_arbiter_if.sv | 21 ++
 rtl/iob_rr_arbiter_prio_enc.sv | 30 +++
 rtl/iob_rr_arbiter.sv | 118 +++++++++++
 tb/tb_iob_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin IOb arbiter.
// The FSM state encoding and the grant/pointer width rule live here.
package iob_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RDATA = 2'd2
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_arbiter_if.sv
// IOb bundle carrying N request lanes with packed address/data/strobe slices.
// The slave side of the arbiter uses the same bundle with N=1.
interface iob_rr_arbiter_if #(
    parameter int N      = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [N-1:0]        valid;
    logic [N*ADDR_W-1:0] addr;
    logic [N*DATA_W-1:0] wdata;
    logic [N*STRB_W-1:0] wstrb;
    logic [N-1:0]        ready;
    logic [N-1:0]        rvalid;
    logic [DATA_W-1:0]   rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rvalid, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rvalid, rdata);

endinterface

// File: rtl/iob_rr_arbiter_prio_enc.sv
// Round-robin priority encoder: picks the first requester at or after ptr,
// wrapping past N-1 back to 0.
module iob_rr_arbiter_prio_enc
    import iob_rr_arbiter_pkg::*;
#(
    parameter int N = 2,
    localparam int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        int k;
        gnt_idx = '0;
        any_req = 1'b0;
        k       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N;
            if (req[IDX_W'(k)]) begin
                gnt_idx = IDX_W'(k);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter sharing one IOb slave among N_MASTERS masters, one
// transaction outstanding; the grant is held until write accept or read data.
module iob_rr_arbiter
    import iob_rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic            clk_i,
    input  logic            arst_n_i,
    iob_rr_arbiter_if.slave  m_bus,
    iob_rr_arbiter_if.master s_bus
);

    localparam int IDX_W  = idx_w(N_MASTERS);
    localparam int STRB_W = DATA_W / 8;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] enc_idx, grant_nxt;
    logic             any_req;

    logic              g_valid;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [STRB_W-1:0] g_wstrb;

    iob_rr_arbiter_prio_enc #(.N(N_MASTERS)) u_prio_enc (
        .req     (m_bus.valid),
        .ptr     (ptr_q),
        .gnt_idx (enc_idx),
        .any_req (any_req)
    );

    always_comb begin
        g_valid = m_bus.valid[grant_q];
        g_addr  = '0;
        g_wdata = '0;
        g_wstrb = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (grant_q == IDX_W'(k)) begin
                g_addr  = m_bus.addr[k*ADDR_W +: ADDR_W];
                g_wdata = m_bus.wdata[k*DATA_W +: DATA_W];
                g_wstrb = m_bus.wstrb[k*STRB_W +: STRB_W];
            end
        end
    end

    assign grant_nxt = (grant_q == IDX_W'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        s_bus.valid  = '0;
        s_bus.addr   = '0;
        s_bus.wdata  = '0;
        s_bus.wstrb  = '0;
        m_bus.ready  = '0;
        m_bus.rvalid = '0;
        m_bus.rdata  = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = enc_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                s_bus.valid[0] = g_valid;
                s_bus.addr     = g_addr;
                s_bus.wdata    = g_wdata;
                s_bus.wstrb    = g_wstrb;
                // A master abandoning its request is dropped without advancing the pointer.
                if (!g_valid) begin
                    state_d = IDLE;
                end else if (s_bus.ready[0]) begin
                    m_bus.ready[grant_q] = 1'b1;
                    if (|g_wstrb) begin
                        ptr_d   = grant_nxt;
                        state_d = IDLE;
                    end else if (s_bus.rvalid[0]) begin
                        m_bus.rvalid[grant_q] = 1'b1;
                        m_bus.rdata           = s_bus.rdata;
                        ptr_d                 = grant_nxt;
                        state_d               = IDLE;
                    end else begin
                        state_d = RDATA;
                    end
                end
            end
            RDATA: begin
                if (s_bus.rvalid[0]) begin
                    m_bus.rvalid[grant_q] = 1'b1;
                    m_bus.rdata           = s_bus.rdata;
                    ptr_d                 = grant_nxt;
                    state_d               = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Scoreboard bench for iob_rr_arbiter with four masters and a behavioural slave.
// Directed tests push hand-computed master-side events; a negedge monitor compares them.
module tb_iob_rr_arbiter;

    typedef struct {
        logic [3:0]  ready;
        logic [3:0]  rvalid;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } evt_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic clk;
    logic arst_n;

    iob_rr_arbiter_if #(.N(4), .ADDR_W(32), .DATA_W(32)) m_if ();
    iob_rr_arbiter_if #(.N(1), .ADDR_W(32), .DATA_W(32)) s_if ();

    iob_rr_arbiter #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .m_bus    (m_if),
        .s_bus    (s_if)
    );

    evt_t        exp_q[$];
    req_t        req_q[4][$];
    int          ready_cyc[$];
    logic [3:0]  ready_seen = '0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    int          ready_delay = 0;
    int          rd_delay = 3;
    bit          rd_same = 1'b0;
    logic [31:0] rd_value = '0;
    int          wait_cnt = 0;
    int          rd_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Master drivers: hold a request until ready is seen, then load the next one.
    initial begin
        req_t r;
        m_if.valid = '0;
        m_if.addr  = '0;
        m_if.wdata = '0;
        m_if.wstrb = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (m_if.valid[k] && ready_seen[k]) m_if.valid[k] = 1'b0;
                if (!m_if.valid[k] && req_q[k].size() > 0) begin
                    r = req_q[k].pop_front();
                    m_if.valid[k]          = 1'b1;
                    m_if.addr[k*32 +: 32]  = r.addr;
                    m_if.wdata[k*32 +: 32] = r.wdata;
                    m_if.wstrb[k*4 +: 4]   = r.wstrb;
                end
            end
        end
    end

    // Slave model: programmable ready delay, read latency, or same-cycle read data.
    initial begin
        s_if.ready  = '0;
        s_if.rvalid = '0;
        s_if.rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            s_if.ready  = '0;
            s_if.rvalid = '0;
            s_if.rdata  = '0;
            if (!arst_n) begin
                wait_cnt = 0;
                rd_cnt   = 0;
            end else if (rd_cnt > 0) begin
                rd_cnt = rd_cnt - 1;
                if (rd_cnt == 0) begin
                    s_if.rvalid = 1'b1;
                    s_if.rdata  = rd_value;
                end
            end else if (s_if.valid[0]) begin
                if (wait_cnt < ready_delay) begin
                    wait_cnt = wait_cnt + 1;
                end else begin
                    wait_cnt   = 0;
                    s_if.ready = 1'b1;
                    if (s_if.wstrb == 4'h0) begin
                        if (rd_same) begin
                            s_if.rvalid = 1'b1;
                            s_if.rdata  = rd_value;
                        end else begin
                            rd_cnt = rd_delay;
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        evt_t e;
        bit   ok;
        @(negedge clk);
        ready_seen = m_if.ready;
        if (arst_n && ((|m_if.ready) || (|m_if.rvalid))) begin
            if (|m_if.ready) ready_cyc.push_back(cyc);
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_event: ready=%b rvalid=%b rdata=%h addr=%h, required no event",
                         m_if.ready, m_if.rvalid, m_if.rdata, s_if.addr);
            end else begin
                e  = exp_q.pop_front();
                ok = (m_if.ready == e.ready) && (m_if.rvalid == e.rvalid);
                if (e.ready != 4'h0)
                    ok = ok && (s_if.addr == e.addr) && (s_if.wdata == e.wdata) && (s_if.wstrb == e.wstrb);
                if (e.rvalid != 4'h0)
                    ok = ok && (m_if.rdata == e.rdata);
                if (!ok) begin
                    errors = errors + 1;
                    $display("FAIL event: got ready=%b rvalid=%b rdata=%h addr=%h wdata=%h wstrb=%h; required ready=%b rvalid=%b rdata=%h addr=%h wdata=%h wstrb=%h",
                             m_if.ready, m_if.rvalid, m_if.rdata, s_if.addr, s_if.wdata, s_if.wstrb,
                             e.ready, e.rvalid, e.rdata, e.addr, e.wdata, e.wstrb);
                end
            end
        end
    end

    task automatic push_req(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_t r;
        r.addr = a; r.wdata = d; r.wstrb = s;
        req_q[k].push_back(r);
    endtask

    task automatic push_exp(input logic [3:0] rdy, input logic [3:0] rv, input logic [31:0] rd,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        evt_t e;
        e.ready = rdy; e.rvalid = rv; e.rdata = rd; e.addr = a; e.wdata = d; e.wstrb = s;
        exp_q.push_back(e);
    endtask

    task automatic exp_write(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        push_exp(4'b0001 << k, 4'h0, 32'h0, a, d, s);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, {s_if.valid, s_if.addr, s_if.wdata, s_if.wstrb, m_if.ready, m_if.rvalid, m_if.rdata}, '0);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || req_q[0].size() != 0 || req_q[1].size() != 0 ||
                req_q[2].size() != 0 || req_q[3].size() != 0 || m_if.valid != 4'h0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_timeout: %0d events still pending after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset_hold");
        arst_n = 1'b1;
        @(negedge clk);
        check_idle("after_reset");

        // Single write with a one-cycle slave wait; grant appears one cycle after request.
        ready_delay = 1;
        push_req(0, 32'h10, 32'hDEADBEEF, 4'hF);
        exp_write(0, 32'h10, 32'hDEADBEEF, 4'hF);
        @(posedge clk);
        @(negedge clk);
        check("latency_idle_cycle", {127'h0, s_if.valid[0]}, 128'h0);
        @(negedge clk);
        check("latency_grant_cycle", {95'h0, s_if.valid[0], s_if.addr}, {95'h0, 1'b1, 32'h10});
        drain("single_write", 50);

        // Read by m1 with data three cycles after acceptance.
        rd_delay = 3;
        rd_value = 32'h12345678;
        push_req(1, 32'h20, 32'h0, 4'h0);
        push_exp(4'b0010, 4'h0, 32'h0, 32'h20, 32'h0, 4'h0);
        push_exp(4'h0, 4'b0010, 32'h12345678, 32'h0, 32'h0, 4'h0);
        drain("read_delay3", 50);

        // Contention right after reset: m0 first both times.
        do_reset();
        ready_delay = 0;
        for (int rep = 0; rep < 2; rep++) begin
            push_req(0, 32'h200 + rep, 32'hA0A0_0000 + rep, 4'hF);
            push_req(1, 32'h300 + rep, 32'hB0B0_0000 + rep, 4'h3);
            exp_write(0, 32'h200 + rep, 32'hA0A0_0000 + rep, 4'hF);
            exp_write(1, 32'h300 + rep, 32'hB0B0_0000 + rep, 4'h3);
            drain("contention", 50);
        end

        // All four masters streaming writes: strict 0,1,2,3 rotation.
        do_reset();
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 4; k++) begin
                push_req(k, 32'h100 + 16*j + 4*k, {16'(k), 16'(j)}, 4'hF);
                exp_write(k, 32'h100 + 16*j + 4*k, {16'(k), 16'(j)}, 4'hF);
            end
        drain("fairness", 200);

        // Move the pointer to 1, then reset during an m2 read and confirm the pointer restarts at 0.
        push_req(0, 32'h50, 32'h5555_0000, 4'hF);
        exp_write(0, 32'h50, 32'h5555_0000, 4'hF);
        drain("ptr_advance", 50);
        rd_delay = 20;
        rd_value = 32'hBAD0BAD0;
        push_req(2, 32'h40, 32'h0, 4'h0);
        push_exp(4'b0100, 4'h0, 32'h0, 32'h40, 32'h0, 4'h0);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("read_accept_before_reset", {127'h0, (n < 50)}, {127'h0, 1'b1});
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        #1;
        check_idle("reset_mid_read");
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        check_idle("after_mid_read_reset");
        push_req(0, 32'h60, 32'h6666_0000, 4'hF);
        push_req(2, 32'h64, 32'h7777_0000, 4'hC);
        exp_write(0, 32'h60, 32'h6666_0000, 4'hF);
        exp_write(2, 32'h64, 32'h7777_0000, 4'hC);
        drain("post_reset", 60);

        // Same-cycle ready and read data, followed immediately by another request.
        rd_same  = 1'b1;
        rd_value = 32'hA5A55A5A;
        ready_cyc.delete();
        push_req(3, 32'h30, 32'h0, 4'h0);
        push_req(3, 32'h34, 32'h1, 4'h1);
        push_exp(4'b1000, 4'b1000, 32'hA5A55A5A, 32'h30, 32'h0, 4'h0);
        exp_write(3, 32'h34, 32'h1, 4'h1);
        drain("same_cycle_rvalid", 50);
        if (ready_cyc.size() == 2)
            check("regrant_spacing", 128'(ready_cyc[1] - ready_cyc[0]), 128'd2);
        else
            check("regrant_events", 128'(ready_cyc.size()), 128'd2);

        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
